// File: rtl/main_memory.sv
// Line-granular backing store: one read (line fill) or write (write-back) at a time,
// with a fixed access latency modelled by a counter-driven FSM.
module main_memory #(
  parameter int LINE_BYTES  = 64,
  parameter int LINE_BITS   = LINE_BYTES * 8,
  parameter int MEM_LINES   = 256,
  parameter int LATENCY     = 5,
  parameter int ADDR_SIZE   = 32,
  parameter int OFFSET_BITS = $clog2(LINE_BYTES),
  parameter int INDEX_BITS  = $clog2(MEM_LINES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_en_i,
  input  logic                 req_rd_wr_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [LINE_BITS-1:0] req_data_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  output logic [LINE_BITS-1:0] rsp_data_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [INDEX_BITS-1:0] r_idx;
  logic                  r_wr;
  logic [LINE_BITS-1:0]  r_data;
  logic [LINE_BITS-1:0]  r_rsp_data;
  logic [LINE_BITS-1:0]  r_mem [MEM_LINES];
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_unused;

  // Offset bits and bits above the index are deliberately dropped (lines alias).
  assign w_unused = ^{req_addr_i[ADDR_SIZE-1:OFFSET_BITS+INDEX_BITS], req_addr_i[OFFSET_BITS-1:0]};

  assign w_accept    = req_en_i && (r_state == S_IDLE);
  assign w_commit    = (r_state == S_BUSY) && (r_cnt == '0);
  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_data_o  = r_rsp_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so the requester may change its inputs afterwards.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx  <= req_addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
      r_wr   <= req_rd_wr_i;
      r_data <= req_data_i;
    end
  end

  // Gating on reset_n drops a write whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_commit && r_wr) begin
      r_mem[r_idx] <= r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_data <= '0;
    end else if (w_commit) begin
      r_rsp_data <= r_wr ? r_data : r_mem[r_idx];
    end
  end

endmodule
